// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory controller: access sizes and FSM states.
package mips_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response and debug bus of the data-memory controller.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DBG_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [DBG_W-1:0]  dbg_idx;
  logic [31:0]       dbg_data;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dbg_idx,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_data
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dbg_idx,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_data
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables/replication and load extraction/extension.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic        misaligned,
  output logic [31:0] rd_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Store data is replicated across lanes so the byte enable alone selects the target.
  always_comb begin
    byte_en    = 4'b1111;
    wr_word    = wdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        byte_en = 4'b0001 << addr_lo;
        wr_word = {4{wdata[7:0]}};
      end
      SZ_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word    = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  always_comb begin
    sel_byte = raw_word[7:0];
    case (addr_lo)
      2'd1:    sel_byte = raw_word[15:8];
      2'd2:    sel_byte = raw_word[23:16];
      2'd3:    sel_byte = raw_word[31:24];
      default: sel_byte = raw_word[7:0];
    endcase
    sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  always_comb begin
    rd_data = raw_word;
    case (size)
      SZ_B: rd_data = is_signed ? {{24{sel_byte[7]}}, sel_byte} : {24'b0, sel_byte};
      SZ_H: rd_data = is_signed ? {{16{sel_half[15]}}, sel_half} : {16'b0, sel_half};
      default: rd_data = raw_word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one load/store at a time with configurable latency,
// byte/half/word access, misalignment detection and a live debug read port.
module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int DBG_W   = 4
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state, state_nx;
  logic [2:0]        cnt;
  logic              accept, commit;

  logic              l_we;
  logic [1:0]        l_size;
  logic              l_signed;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  mem_idx;
  logic [IDX_W-1:0]  dbg_mem_idx;
  logic [31:0]       raw_word;

  logic [3:0]        byte_en;
  logic [31:0]       wr_word;
  logic              misaligned;
  logic [31:0]       ld_data;

  // Addresses beyond DEPTH wrap by truncating the word index.
  assign mem_idx     = IDX_W'(l_addr[ADDR_W-1:2]);
  assign dbg_mem_idx = IDX_W'(bus.dbg_idx);
  assign raw_word    = mem[mem_idx];
  assign bus.dbg_data  = mem[dbg_mem_idx];
  assign bus.req_ready = (state == ST_IDLE);

  mem_lane_align u_align (
    .size       (l_size),
    .is_signed  (l_signed),
    .addr_lo    (l_addr[1:0]),
    .wdata      (l_wdata),
    .raw_word   (raw_word),
    .byte_en    (byte_en),
    .wr_word    (wr_word),
    .misaligned (misaligned),
    .rd_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == 3'd0) begin
          commit   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 3'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
      l_we          <= 1'b0;
      l_size        <= SZ_W;
      l_signed      <= 1'b0;
      l_addr        <= '0;
      l_wdata       <= 32'd0;
    end else begin
      bus.rsp_valid <= commit;
      if (accept) begin
        cnt      <= 3'(LATENCY - 1);
        l_we     <= bus.req_we;
        l_size   <= bus.req_size;
        l_signed <= bus.req_signed;
        l_addr   <= bus.req_addr;
        l_wdata  <= bus.req_wdata;
      end else if (state == ST_BUSY && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (commit) begin
        bus.rsp_err   <= misaligned;
        bus.rsp_rdata <= (misaligned || l_we) ? 32'd0 : ld_data;
      end
    end
  end

  // Memory has no reset; a reset on the commit edge still suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && l_we && !misaligned) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[mem_idx][8*k +: 8] <= wr_word[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances with LATENCY 1, 3 and 4 share one stimulus bus.
module tb_data_mem_ctrl;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SZ_W;
  logic        req_signed = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  dbg_idx = '0;

  logic        o_ready, o_rsp_valid, o_err;
  logic [31:0] o_rdata, o_dbg;

  int checks = 0;
  int fails  = 0;
  int lat, acc, pulses;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(12), .DBG_W(4)) bus1 ();
  data_mem_ctrl_if #(.ADDR_W(12), .DBG_W(4)) bus3 ();
  data_mem_ctrl_if #(.ADDR_W(12), .DBG_W(4)) bus4 ();

  data_mem_ctrl #(.ADDR_W(12), .DEPTH(1024), .LATENCY(1), .DBG_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  data_mem_ctrl #(.ADDR_W(12), .DEPTH(1024), .LATENCY(3), .DBG_W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  data_mem_ctrl #(.ADDR_W(12), .DEPTH(1024), .LATENCY(4), .DBG_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus1.req_valid = req_valid && (sel == 0);
  assign bus3.req_valid = req_valid && (sel == 1);
  assign bus4.req_valid = req_valid && (sel == 2);
  assign bus1.req_we = req_we;  assign bus3.req_we = req_we;  assign bus4.req_we = req_we;
  assign bus1.req_size = req_size;  assign bus3.req_size = req_size;  assign bus4.req_size = req_size;
  assign bus1.req_signed = req_signed;  assign bus3.req_signed = req_signed;  assign bus4.req_signed = req_signed;
  assign bus1.req_addr = req_addr;  assign bus3.req_addr = req_addr;  assign bus4.req_addr = req_addr;
  assign bus1.req_wdata = req_wdata;  assign bus3.req_wdata = req_wdata;  assign bus4.req_wdata = req_wdata;
  assign bus1.dbg_idx = dbg_idx;  assign bus3.dbg_idx = dbg_idx;  assign bus4.dbg_idx = dbg_idx;

  always_comb begin
    o_ready = bus1.req_ready;  o_rsp_valid = bus1.rsp_valid;
    o_rdata = bus1.rsp_rdata;  o_err = bus1.rsp_err;  o_dbg = bus1.dbg_data;
    if (sel == 1) begin
      o_ready = bus3.req_ready;  o_rsp_valid = bus3.rsp_valid;
      o_rdata = bus3.rsp_rdata;  o_err = bus3.rsp_err;  o_dbg = bus3.dbg_data;
    end else if (sel == 2) begin
      o_ready = bus4.req_ready;  o_rsp_valid = bus4.rsp_valid;
      o_rdata = bus4.rsp_rdata;  o_err = bus4.rsp_err;  o_dbg = bus4.dbg_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request, returns the number of negedges until rsp_valid (20 = timeout).
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [11:0] addr, input logic [31:0] wdata, output int cyc);
    @(negedge clk);
    req_valid = 1'b1;  req_we = we;  req_size = size;
    req_signed = sgn;  req_addr = addr;  req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = 32'h0;
    cyc = 0;
    while (!o_rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    // Reset defaults
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    checkOutput("rst_rdata", o_rdata, 32'd0);
    checkOutput("rst_err", {31'b0, o_err}, 32'd0);
    rst = 1'b0;

    // Word store/load, LATENCY=1
    applyStimulus(1'b1, SZ_W, 1'b0, 12'h010, 32'h11223344, lat);
    checkOutput("st_w_lat", lat, 2);
    checkOutput("st_w_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("st_w_err", {31'b0, o_err}, 32'd0);
    @(negedge clk);
    checkOutput("st_w_pulse", {31'b0, o_rsp_valid}, 32'd0);
    dbg_idx = 4'd4;
    #1 checkOutput("st_w_dbg", o_dbg, 32'h11223344);
    applyStimulus(1'b0, SZ_W, 1'b1, 12'h010, 32'h0, lat);
    checkOutput("ld_w_lat", lat, 2);
    checkOutput("ld_w_data", o_rdata, 32'h11223344);
    checkOutput("ld_w_err", {31'b0, o_err}, 32'd0);

    // Byte/half stores and extended loads
    applyStimulus(1'b1, SZ_B, 1'b0, 12'h012, 32'hFFFFFFAB, lat);
    checkOutput("st_b_rdata", o_rdata, 32'd0);
    @(negedge clk);
    checkOutput("st_b_dbg", o_dbg, 32'h11AB3344);
    applyStimulus(1'b0, SZ_B, 1'b1, 12'h012, 32'h0, lat);
    checkOutput("ld_bs", o_rdata, 32'hFFFFFFAB);
    applyStimulus(1'b0, SZ_B, 1'b0, 12'h012, 32'h0, lat);
    checkOutput("ld_bu", o_rdata, 32'h000000AB);
    applyStimulus(1'b1, SZ_H, 1'b0, 12'h010, 32'h12348001, lat);
    applyStimulus(1'b0, SZ_H, 1'b1, 12'h010, 32'h0, lat);
    checkOutput("ld_hs", o_rdata, 32'hFFFF8001);
    applyStimulus(1'b0, SZ_H, 1'b1, 12'h012, 32'h0, lat);
    checkOutput("ld_hs_hi", o_rdata, 32'h000011AB);
    applyStimulus(1'b0, SZ_B, 1'b1, 12'h011, 32'h0, lat);
    checkOutput("ld_bs_lane1", o_rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'd3, 1'b1, 12'h010, 32'h0, lat);
    checkOutput("ld_size3", o_rdata, 32'h11AB8001);

    // Misaligned accesses
    applyStimulus(1'b1, SZ_W, 1'b0, 12'h011, 32'hDEADBEEF, lat);
    checkOutput("mis_w_lat", lat, 2);
    checkOutput("mis_w_err", {31'b0, o_err}, 32'd1);
    checkOutput("mis_w_rdata", o_rdata, 32'd0);
    @(negedge clk);
    checkOutput("mis_w_dbg", o_dbg, 32'h11AB8001);
    applyStimulus(1'b0, SZ_H, 1'b0, 12'h013, 32'h0, lat);
    checkOutput("mis_h_err", {31'b0, o_err}, 32'd1);
    checkOutput("mis_h_rdata", o_rdata, 32'd0);

    // Address wrap onto distinct words 1023 and 0
    applyStimulus(1'b1, SZ_W, 1'b0, 12'hFFC, 32'hCAFEF00D, lat);
    applyStimulus(1'b1, SZ_W, 1'b0, 12'h000, 32'h0BADBEEF, lat);
    applyStimulus(1'b0, SZ_W, 1'b0, 12'hFFC, 32'h0, lat);
    checkOutput("wrap_1023", o_rdata, 32'hCAFEF00D);
    applyStimulus(1'b0, SZ_W, 1'b0, 12'h000, 32'h0, lat);
    checkOutput("wrap_0", o_rdata, 32'h0BADBEEF);
    dbg_idx = 4'd0;
    #1 checkOutput("wrap_dbg0", o_dbg, 32'h0BADBEEF);

    // LATENCY=3 instance
    sel = 1;
    applyStimulus(1'b1, SZ_W, 1'b0, 12'h040, 32'hA5A5A5A5, lat);
    checkOutput("lat3_st", lat, 4);
    applyStimulus(1'b0, SZ_W, 1'b0, 12'h040, 32'h0, lat);
    checkOutput("lat3_ld_lat", lat, 4);
    checkOutput("lat3_ld_data", o_rdata, 32'hA5A5A5A5);

    // Request held through BUSY is accepted once; payload changes are ignored
    @(negedge clk);
    req_valid = 1'b1;  req_we = 1'b1;  req_size = SZ_W;
    req_addr = 12'h020;  req_wdata = 32'h00000077;
    acc = 0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (o_ready) acc++;
      @(posedge clk);
      #1 req_wdata = 32'h00000099;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_rsp_valid) pulses++;
      @(negedge clk);
    end
    checkOutput("held_accepts", acc, 1);
    checkOutput("held_pulses", pulses, 1);
    dbg_idx = 4'd8;
    #1 checkOutput("held_dbg", o_dbg, 32'h00000077);

    // Reset during a LATENCY=4 store drops it
    sel = 2;
    applyStimulus(1'b1, SZ_W, 1'b0, 12'h008, 32'h12345678, lat);
    checkOutput("lat4_st", lat, 5);
    @(negedge clk);
    req_valid = 1'b1;  req_we = 1'b1;  req_size = SZ_B;
    req_addr = 12'h008;  req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_ready", {31'b0, o_ready}, 32'd1);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_rsp_valid) pulses++;
      @(negedge clk);
    end
    checkOutput("midrst_pulses", pulses, 0);
    dbg_idx = 4'd2;
    #1 checkOutput("midrst_dbg", o_dbg, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
